// File: rtl/ibm1620_timing_pkg.sv
// Shared timing constants and enums for the IBM 1620 core-memory cycle timer.
package ibm1620_timing_pkg;

    localparam int STEPS_DEF       = 20;
    localparam int RING_W_DEF      = STEPS_DEF / 2;
    localparam int READ_FIRST_DEF  = 0;
    localparam int READ_LAST_DEF   = 5;
    localparam int STROBE_STEP_DEF = 4;
    localparam int INH_FIRST_DEF   = 9;
    localparam int INH_LAST_DEF    = 16;
    localparam int WRITE_FIRST_DEF = 10;
    localparam int WRITE_LAST_DEF  = 15;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_e;

    // Coarse phase of a memory cycle, for debug display only.
    typedef enum logic [2:0] {
        PH_IDLE,
        PH_READ,
        PH_GAP,
        PH_WRITE,
        PH_TAIL
    } phase_e;

    function automatic phase_e phase_of(input logic active, input int step);
        if (!active)
            return PH_IDLE;
        if (step <= READ_LAST_DEF)
            return PH_READ;
        if (step < WRITE_FIRST_DEF)
            return PH_GAP;
        if (step <= WRITE_LAST_DEF)
            return PH_WRITE;
        return PH_TAIL;
    endfunction

endpackage

// File: rtl/ibm1620_core_cycle_timer_step_window.sv
// Step-window decoder: gate is high while active and cnt lies in [FIRST..LAST].
module ibm1620_step_window
    import ibm1620_timing_pkg::*;
#(
    parameter int CW    = 5,
    parameter int FIRST = 0,
    parameter int LAST  = 0
) (
    input  logic [CW-1:0] cnt,
    input  logic          active,
    output logic          gate
);

    // Signed compare keeps FIRST=0 from becoming a constant-true unsigned test.
    assign gate = active && (int'(cnt) >= FIRST) && (int'(cnt) <= LAST);

endmodule

// File: rtl/ibm1620_core_cycle_timer.sv
// IBM 1620 core-memory cycle timer: steps through one read/rewrite cycle per request.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | no cycle in progress, cnt held at 0, all gates low
//  ST_ACTIVE | cycle running, cnt = current step, advances on step_en
//
// Every output except cycle_done is a flop loaded from the next-state decode,
// so outputs always line up with the step the counter currently holds.
// cycle_done needs the live step_en to mark only the qualified last clk.
module ibm1620_core_cycle_timer
    import ibm1620_timing_pkg::*;
#(
    parameter int STEPS       = STEPS_DEF,
    parameter int READ_FIRST  = READ_FIRST_DEF,
    parameter int READ_LAST   = READ_LAST_DEF,
    parameter int STROBE_STEP = STROBE_STEP_DEF,
    parameter int INH_FIRST   = INH_FIRST_DEF,
    parameter int INH_LAST    = INH_LAST_DEF,
    parameter int WRITE_FIRST = WRITE_FIRST_DEF,
    parameter int WRITE_LAST  = WRITE_LAST_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step_en,
    input  logic               cycle_req,
    output logic               busy,
    output logic [STEPS/2-1:0] t_ring,
    output logic               rd_drive,
    output logic               sense_strobe,
    output logic               inhibit_gate,
    output logic               wr_drive,
    output logic               cycle_done
);

    localparam int CW = $clog2(STEPS);
    localparam int RW = STEPS / 2;
    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

    // Parameter sanity: overlapping read/write drive would fight the X/Y lines.
    if ((STEPS < 8) || ((STEPS % 2) != 0)) begin : g_bad_steps
        $error("ibm1620_core_cycle_timer: STEPS must be even and >= 8");
    end
    if ((READ_FIRST <= WRITE_LAST) && (WRITE_FIRST <= READ_LAST)) begin : g_bad_overlap
        $error("ibm1620_core_cycle_timer: read and write drive windows overlap");
    end

    state_e          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            active_n;
    logic [RW-1:0]   ring_n;
    logic            rd_n, strobe_n, inh_n, wr_n, last_n;

    logic            busy_q, rd_q, strobe_q, inh_q, wr_q, last_q;
    logic [RW-1:0]   ring_q;

    // Next-state: start from idle, advance on step_en, wrap or retire on last step.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cycle_req && step_en) begin
                    state_n = ST_ACTIVE;
                    cnt_n   = '0;
                end
            end
            ST_ACTIVE: begin
                if (step_en) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_n   = '0;
                        state_n = cycle_req ? ST_ACTIVE : ST_IDLE;
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign active_n = (state_n == ST_ACTIVE);

    ibm1620_step_window #(.CW(CW), .FIRST(READ_FIRST), .LAST(READ_LAST)) u_win_read (
        .cnt    (cnt_n),
        .active (active_n),
        .gate   (rd_n)
    );

    ibm1620_step_window #(.CW(CW), .FIRST(STROBE_STEP), .LAST(STROBE_STEP)) u_win_strobe (
        .cnt    (cnt_n),
        .active (active_n),
        .gate   (strobe_n)
    );

    ibm1620_step_window #(.CW(CW), .FIRST(INH_FIRST), .LAST(INH_LAST)) u_win_inhibit (
        .cnt    (cnt_n),
        .active (active_n),
        .gate   (inh_n)
    );

    ibm1620_step_window #(.CW(CW), .FIRST(WRITE_FIRST), .LAST(WRITE_LAST)) u_win_write (
        .cnt    (cnt_n),
        .active (active_n),
        .gate   (wr_n)
    );

    // Ring position and last-step marker decoded from the next state.
    always_comb begin
        ring_n = '0;
        last_n = 1'b0;
        if (active_n) begin
            ring_n = RW'(1) << cnt_n[CW-1:1];
            last_n = (cnt_n == LAST_CNT);
        end
    end

    // State and output registers; synchronous active-low reset aborts any cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            ring_q   <= '0;
            rd_q     <= 1'b0;
            strobe_q <= 1'b0;
            inh_q    <= 1'b0;
            wr_q     <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            busy_q   <= active_n;
            ring_q   <= ring_n;
            rd_q     <= rd_n;
            strobe_q <= strobe_n;
            inh_q    <= inh_n;
            wr_q     <= wr_n;
            last_q   <= last_n;
        end
    end

    assign busy         = busy_q;
    assign t_ring       = ring_q;
    assign rd_drive     = rd_q;
    assign sense_strobe = strobe_q;
    assign inhibit_gate = inh_q;
    assign wr_drive     = wr_q;
    assign cycle_done   = last_q & step_en;

endmodule

// File: tb/tb_ibm1620_core_cycle_timer.sv
// Self-checking bench for ibm1620_core_cycle_timer with a step-level scoreboard.
module tb_ibm1620_core_cycle_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       step_en;
    logic       cycle_req;
    logic       busy;
    logic [9:0] t_ring;
    logic       rd_drive;
    logic       sense_strobe;
    logic       inhibit_gate;
    logic       wr_drive;
    logic       cycle_done;

    ibm1620_core_cycle_timer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .step_en      (step_en),
        .cycle_req    (cycle_req),
        .busy         (busy),
        .t_ring       (t_ring),
        .rd_drive     (rd_drive),
        .sense_strobe (sense_strobe),
        .inhibit_gate (inhibit_gate),
        .wr_drive     (wr_drive),
        .cycle_done   (cycle_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic [9:0] ring;
        logic       rd;
        logic       st;
        logic       inh;
        logic       wr;
        logic       last;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic m_active = 1'b0;
    int   m_cnt    = 0;

    logic       obs_busy, obs_done, obs_rd, obs_wr;
    logic [9:0] obs_ring;

    // Expected outputs for a given model state, using the default step windows.
    function automatic exp_t decode(input logic a, input int c);
        exp_t e;
        e.busy = a;
        e.ring = a ? (10'd1 << (c / 2)) : 10'd0;
        e.rd   = a && (c <= 5);
        e.st   = a && (c == 4);
        e.inh  = a && (c >= 9) && (c <= 16);
        e.wr   = a && (c >= 10) && (c <= 15);
        e.last = a && (c == 19);
        return e;
    endfunction

    // One clk: apply inputs at negedge, check current outputs, then predict next state.
    task automatic step(input logic req, input logic en, input logic rn);
        exp_t        e;
        logic [15:0] act;
        logic [15:0] expv;
        @(negedge clk);
        cycle_req = req;
        step_en   = en;
        rst_n     = rn;
        #1;
        obs_busy = busy;
        obs_done = cycle_done;
        obs_rd   = rd_drive;
        obs_wr   = wr_drive;
        obs_ring = t_ring;
        if (sb_q.size() > 0) begin
            e    = sb_q.pop_front();
            expv = {e.busy, e.ring, e.rd, e.st, e.inh, e.wr, e.last && en};
            act  = {busy, t_ring, rd_drive, sense_strobe, inhibit_gate, wr_drive, cycle_done};
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL outputs t=%0t {busy,ring,rd,st,inh,wr,done} actual %h expected %h",
                         $time, act, expv);
            end
        end
        if (!rn) begin
            m_active = 1'b0;
            m_cnt    = 0;
        end else if (!m_active) begin
            if (req && en) begin
                m_active = 1'b1;
                m_cnt    = 0;
            end
        end else if (en) begin
            if (m_cnt == 19) begin
                m_cnt    = 0;
                m_active = req;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        sb_q.push_back(decode(m_active, m_cnt));
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_busy !== 1'b0 || obs_ring !== 10'd0 || obs_rd !== 1'b0 || obs_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_state actual busy=%b ring=%h rd=%b wr=%b required all 0",
                     obs_busy, obs_ring, obs_rd, obs_wr);
        end
        step(1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_single();
        int nb = 0;
        int nd = 0;
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 25; i++) begin
            step(1'b0, 1'b1, 1'b1);
            nb += int'(obs_busy);
            nd += int'(obs_done);
            if (obs_done) begin
                checks++;
                if (obs_ring !== 10'h200) begin
                    errors++;
                    $display("FAIL single_done_ring actual %h required 200", obs_ring);
                end
            end
        end
        checks++;
        if (nb != 20) begin
            errors++;
            $display("FAIL single_busy_len actual %0d required 20", nb);
        end
        checks++;
        if (nd != 1) begin
            errors++;
            $display("FAIL single_done_count actual %0d required 1", nd);
        end
    endtask

    task automatic test_back_to_back();
        int nb = 0;
        int nd = 0;
        int last_done = -1;
        int gap_err = 0;
        for (int i = 0; i < 85; i++) begin
            step((i < 60) ? 1'b1 : 1'b0, 1'b1, 1'b1);
            nb += int'(obs_busy);
            if (obs_done) begin
                nd++;
                if (last_done >= 0 && (i - last_done) != 20) gap_err++;
                last_done = i;
            end
        end
        checks++;
        if (nb != 60) begin
            errors++;
            $display("FAIL b2b_busy_len actual %0d required 60", nb);
        end
        checks++;
        if (nd != 3) begin
            errors++;
            $display("FAIL b2b_done_count actual %0d required 3", nd);
        end
        checks++;
        if (gap_err != 0) begin
            errors++;
            $display("FAIL b2b_done_spacing actual %0d bad intervals required 0", gap_err);
        end
    endtask

    task automatic test_stall();
        int nb = 0;
        int nd = 0;
        step(1'b1, 1'b1, 1'b1);
        for (int j = 0; j < 50; j++) begin
            step(1'b0, (j % 2) == 1, 1'b1);
            nb += int'(obs_busy);
            nd += int'(obs_done);
        end
        checks++;
        if (nb != 40) begin
            errors++;
            $display("FAIL stall_busy_len actual %0d required 40", nb);
        end
        checks++;
        if (nd != 1) begin
            errors++;
            $display("FAIL stall_done_count actual %0d required 1", nd);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (obs_wr !== 1'b1) begin
            errors++;
            $display("FAIL mid_wr_before_reset actual %b required 1", obs_wr);
        end
        step(1'b1, 1'b1, 1'b1);
        checks++;
        if (obs_busy !== 1'b0 || obs_wr !== 1'b0 || obs_ring !== 10'd0) begin
            errors++;
            $display("FAIL mid_after_reset actual busy=%b wr=%b ring=%h required 0 0 000",
                     obs_busy, obs_wr, obs_ring);
        end
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (obs_busy !== 1'b1 || obs_rd !== 1'b1 || obs_ring !== 10'h001) begin
            errors++;
            $display("FAIL mid_restart actual busy=%b rd=%b ring=%h required 1 1 001",
                     obs_busy, obs_rd, obs_ring);
        end
        for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_drop();
        int nb = 0;
        int nd = 0;
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 28; i++) begin
            step((i < 3) ? 1'b1 : 1'b0, 1'b1, 1'b1);
            nb += int'(obs_busy);
            nd += int'(obs_done);
        end
        checks++;
        if (nb != 20) begin
            errors++;
            $display("FAIL drop_busy_len actual %0d required 20", nb);
        end
        checks++;
        if (nd != 1) begin
            errors++;
            $display("FAIL drop_done_count actual %0d required 1", nd);
        end
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_final_idle actual %b required 0", obs_busy);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        step_en   = 1'b0;
        cycle_req = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
